// File: rtl/mdu_pkg.sv
// Shared encodings for the sequential multiply/divide unit.
// Divide support is selected by the MDU_DIV_EN macro in mdu_step and mdu_seq.
package mdu_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_RUN  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } mdu_state_e;

    localparam int unsigned MDU_ITER      = 32;
    localparam logic [5:0]  MDU_LAST_ITER = 6'(MDU_ITER - 1);

    function automatic logic op_is_div(input mdu_op_e op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input mdu_op_e op);
        return ~op[0];
    endfunction

    function automatic logic [31:0] cond_neg32(input logic [31:0] v, input logic neg);
        return neg ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/mdu_step.sv
// One iteration of the multiply (shift-add) or restoring divide datapath.
// The divide half only exists when MDU_DIV_EN is defined.
module mdu_step
    import mdu_pkg::*;
(
    input  logic        div_mode,
    input  logic [63:0] acc,
    input  logic [31:0] operand,
    output logic [63:0] acc_next
);

    logic [32:0] mul_sum;
    logic [63:0] mul_next;

    always_comb begin
        mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, operand} : 33'd0);
        mul_next = {mul_sum, acc[31:1]};
    end

`ifdef MDU_DIV_EN
    logic [32:0] rem_shift;
    logic [33:0] trial;
    logic        borrow;
    logic [63:0] div_next;

    // Partial remainder stays below the divisor, so the restored value fits 32 bits.
    always_comb begin
        rem_shift = acc[63:31];
        trial     = {1'b0, rem_shift} - {2'b00, operand};
        borrow    = trial[33];
        div_next  = {(borrow ? rem_shift[31:0] : trial[31:0]), acc[30:0], ~borrow};
        acc_next  = div_mode ? div_next : mul_next;
    end
`else
    always_comb begin
        acc_next = div_mode ? 64'd0 : mul_next;
    end
`endif

endmodule

// File: rtl/mdu_seq.sv
// Sequential 32-iteration multiply/divide unit with cancel and async active-low reset.
// Define MDU_DIV_EN to include DIV/DIVU; otherwise divide ops finish at once with err=1.
module mdu_seq
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        clrn,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cancel,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        err
);

    mdu_state_e  state_reg, state_next;
    mdu_op_e     op_reg;
    logic        prep_phase_reg;
    logic [5:0]  count_reg;
    logic [31:0] a_reg, b_reg;
    logic [31:0] opa_reg, opb_reg;
    logic        neg_res_reg, neg_rem_reg;
    logic [63:0] acc_reg;
    logic [31:0] hi_reg, lo_reg;
    logic        err_reg;

    logic        accept;
    logic        load_abs, load_acc, step_en;
    logic        commit_fix, commit_div0, commit_nodiv;
    logic        sign_a, sign_b;
    logic [63:0] step_next;
    logic [63:0] prod_fixed;
    logic [31:0] quo_fixed, rem_fixed;

    assign accept = ((state_reg == ST_IDLE) || (state_reg == ST_DONE)) && start && !cancel;
    assign sign_a = op_is_signed(op_reg) & a_reg[31];
    assign sign_b = op_is_signed(op_reg) & b_reg[31];

    mdu_step u_step (
        .div_mode (op_is_div(op_reg)),
        .acc      (acc_reg),
        .operand  (op_is_div(op_reg) ? opb_reg : opa_reg),
        .acc_next (step_next)
    );

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // PREP spans two cycles: magnitudes first, then divide-by-zero check and accumulator load.
    always_comb begin
        state_next   = state_reg;
        busy         = 1'b0;
        done         = 1'b0;
        load_abs     = 1'b0;
        load_acc     = 1'b0;
        step_en      = 1'b0;
        commit_fix   = 1'b0;
        commit_div0  = 1'b0;
        commit_nodiv = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (accept) state_next = ST_PREP;
            end
            ST_PREP: begin
                busy = 1'b1;
                if (!prep_phase_reg) begin
`ifdef MDU_DIV_EN
                    load_abs = 1'b1;
`else
                    if (op_is_div(op_reg)) begin
                        commit_nodiv = 1'b1;
                        state_next   = ST_DONE;
                    end else begin
                        load_abs = 1'b1;
                    end
`endif
                end else begin
`ifdef MDU_DIV_EN
                    if (op_is_div(op_reg) && (opb_reg == 32'd0)) begin
                        commit_div0 = 1'b1;
                        state_next  = ST_DONE;
                    end else begin
                        load_acc   = 1'b1;
                        state_next = ST_RUN;
                    end
`else
                    load_acc   = 1'b1;
                    state_next = ST_RUN;
`endif
                end
            end
            ST_RUN: begin
                busy    = 1'b1;
                step_en = 1'b1;
                if (count_reg == MDU_LAST_ITER) state_next = ST_FIX;
            end
            ST_FIX: begin
                busy       = 1'b1;
                commit_fix = 1'b1;
                state_next = ST_DONE;
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = accept ? ST_PREP : ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        if (cancel) begin
            state_next   = ST_IDLE;
            load_abs     = 1'b0;
            load_acc     = 1'b0;
            step_en      = 1'b0;
            commit_fix   = 1'b0;
            commit_div0  = 1'b0;
            commit_nodiv = 1'b0;
        end
    end

    always_comb begin
        prod_fixed = neg_res_reg ? (64'd0 - acc_reg) : acc_reg;
        quo_fixed  = cond_neg32(acc_reg[31:0], neg_res_reg);
        rem_fixed  = cond_neg32(acc_reg[63:32], neg_rem_reg);
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            op_reg         <= MDU_MULT;
            prep_phase_reg <= 1'b0;
            count_reg      <= 6'd0;
            a_reg          <= 32'd0;
            b_reg          <= 32'd0;
            opa_reg        <= 32'd0;
            opb_reg        <= 32'd0;
            neg_res_reg    <= 1'b0;
            neg_rem_reg    <= 1'b0;
            acc_reg        <= 64'd0;
            hi_reg         <= 32'd0;
            lo_reg         <= 32'd0;
            err_reg        <= 1'b0;
        end else begin
            prep_phase_reg <= load_abs;
            if (accept) begin
                op_reg <= mdu_op_e'(op);
                a_reg  <= a;
                b_reg  <= b;
            end
            if (load_abs) begin
                opa_reg     <= cond_neg32(a_reg, sign_a);
                opb_reg     <= cond_neg32(b_reg, sign_b);
                neg_res_reg <= sign_a ^ sign_b;
                neg_rem_reg <= sign_a;
            end
            if (load_acc) begin
                acc_reg   <= {32'd0, (op_is_div(op_reg) ? opa_reg : opb_reg)};
                count_reg <= 6'd0;
            end
            if (step_en) begin
                acc_reg   <= step_next;
                count_reg <= count_reg + 6'd1;
            end
            if (commit_fix) begin
                if (op_is_div(op_reg)) begin
                    hi_reg <= rem_fixed;
                    lo_reg <= quo_fixed;
                end else begin
                    hi_reg <= prod_fixed[63:32];
                    lo_reg <= prod_fixed[31:0];
                end
                err_reg <= 1'b0;
            end
            if (commit_div0) begin
                hi_reg  <= a_reg;
                lo_reg  <= 32'hFFFF_FFFF;
                err_reg <= 1'b1;
            end
            if (commit_nodiv) begin
                hi_reg  <= 32'd0;
                lo_reg  <= 32'd0;
                err_reg <= 1'b1;
            end
        end
    end

    assign hi  = hi_reg;
    assign lo  = lo_reg;
    assign err = err_reg;

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: arithmetic reference model plus directed cases.
// Honors MDU_DIV_EN the same way as the design.
module tb_mdu_seq;

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic        start = 1'b0;
    logic        cancel = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy, done, err;
    logic [31:0] hi, lo;

    always #5 clk = ~clk;

    mdu_seq dut (
        .clk    (clk),
        .clrn   (clrn),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .cancel (cancel),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo),
        .err    (err)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        err;
        int          lat;
    } res_t;

    // Reference result and completion latency straight from the arithmetic definition.
    function automatic res_t calc(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        res_t        r;
        longint      sp;
        logic [63:0] up;
        int          sx, sy, q, rr;
        r.hi = 32'd0; r.lo = 32'd0; r.err = 1'b0; r.lat = 35;
        sx = x; sy = y;
        case (o)
            2'b00: begin
                sp = longint'($signed(x)) * longint'($signed(y));
                up = sp;
                r.hi = up[63:32]; r.lo = up[31:0];
            end
            2'b01: begin
                up = {32'd0, x} * {32'd0, y};
                r.hi = up[63:32]; r.lo = up[31:0];
            end
            default: begin
`ifdef MDU_DIV_EN
                if (y == 32'd0) begin
                    r.hi = x; r.lo = 32'hFFFF_FFFF; r.err = 1'b1; r.lat = 2;
                end else if (o == 2'b11) begin
                    r.lo = x / y; r.hi = x % y;
                end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    r.lo = 32'h8000_0000; r.hi = 32'd0;
                end else begin
                    q = sx / sy; rr = sx % sy;
                    r.lo = q; r.hi = rr;
                end
`else
                r.hi = 32'd0; r.lo = 32'd0; r.err = 1'b1; r.lat = 1;
`endif
            end
        endcase
        return r;
    endfunction

    int          m_left;
    logic        m_done;
    logic [31:0] m_hi, m_lo;
    logic        m_err;
    res_t        m_pend;

    always @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            m_left <= 0; m_done <= 1'b0;
            m_hi <= 32'd0; m_lo <= 32'd0; m_err <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (cancel) begin
                m_left <= 0;
            end else if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_done <= 1'b1;
                    m_hi <= m_pend.hi; m_lo <= m_pend.lo; m_err <= m_pend.err;
                end
            end else if (start) begin
                m_pend <= calc(op, a, b);
                m_left <= calc(op, a, b).lat;
            end
        end
    end

    always @(negedge clk) begin
        check("busy", 32'(busy), 32'(m_left > 0));
        check("done", 32'(done), 32'(m_done));
        check("hi", hi, m_hi);
        check("lo", lo, m_lo);
        if (m_done) check("err", 32'(err), 32'(m_err));
        check("busy_done_excl", 32'(busy & done), 32'd0);
    end

    task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] eh, input logic [31:0] el, input logic ee,
                         input int elat, input string nm);
        int n;
        @(posedge clk); #1;
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (n < 60 && !done) begin
            @(posedge clk); n++; #1;
        end
        check({nm, "_lat"}, 32'(n), 32'(elat));
        check({nm, "_hi"}, hi, eh);
        check({nm, "_lo"}, lo, el);
        check({nm, "_err"}, 32'(err), 32'(ee));
    endtask

    function automatic logic [31:0] pick();
        case ($urandom % 8)
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return $urandom % 16;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n, dcount;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_err", 32'(err), 32'd0);
        clrn = 1'b1;

        do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 35, "multu_max");
        do_op(2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 35, "mult_neg");
`ifdef MDU_DIV_EN
        do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 35, "div_neg");
        do_op(2'b11, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1'b1, 2, "divu_zero");
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 35, "div_ovf");
        do_op(2'b11, 32'd1000, 32'd7, 32'd6, 32'd142, 1'b0, 35, "divu_basic");
`else
        do_op(2'b11, 32'd100, 32'd0, 32'd0, 32'd0, 1'b1, 1, "divu_nodiv");
`endif

        // Cancel mid-multiply: results must keep the previous product.
        do_op(2'b01, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0, 35, "multu_5x6");
        @(posedge clk); #1;
        start = 1'b1; op = 2'b00; a = 32'd7; b = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1 cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        @(posedge clk); #1;
        check("cancel_busy", 32'(busy), 32'd0);
        check("cancel_hi", hi, 32'd0);
        check("cancel_lo", lo, 32'd30);
        dcount = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("cancel_no_done", 32'(dcount), 32'd0);
        do_op(2'b00, 32'd7, 32'd9, 32'd0, 32'd63, 1'b0, 35, "restart");

        // Back-to-back: start held high through the DONE cycle.
        @(posedge clk); #1;
        start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd4;
        @(posedge clk); #1;
        a = 32'd11; b = 32'd13;
        n = 0;
        while (n < 60 && !done) begin
            @(posedge clk); n++; #1;
        end
        check("b2b_first_lat", 32'(n), 32'd35);
        check("b2b_first_lo", lo, 32'd12);
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_reaccept_busy", 32'(busy), 32'd1);
        n = 0;
        while (n < 60 && !done) begin
            @(posedge clk); n++; #1;
        end
        check("b2b_second_lat", 32'(n), 32'd35);
        check("b2b_second_lo", lo, 32'd143);

        // Asynchronous reset in the middle of RUN.
        @(posedge clk); #1;
        start = 1'b1; op = 2'b01; a = 32'd21; b = 32'd2;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #3 clrn = 1'b0;
        #1;
        check("clrn_busy", 32'(busy), 32'd0);
        check("clrn_done", 32'(done), 32'd0);
        check("clrn_hi", hi, 32'd0);
        check("clrn_lo", lo, 32'd0);
        check("clrn_err", 32'(err), 32'd0);
        @(posedge clk); #1;
        clrn = 1'b1;
        do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1, 1'b0, 35, "after_clrn");

        // Randomized traffic, including starts while busy and occasional cancels.
        repeat (2500) begin
            @(posedge clk); #1;
            start  = (($urandom % 3) == 0);
            op     = 2'($urandom);
            a      = pick();
            b      = pick();
            cancel = (($urandom % 50) == 0);
        end
        @(posedge clk); #1;
        start = 1'b0; cancel = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mdu_seq.md
MDU_SEQ -- requirements
Module: mdu_seq

Interface
REQ-001 Parameters: none; iteration count fixed at 32.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 clrn  input  1  reset; one clock, reset asynchronous and active-low.
REQ-004 start  input  1  request, sampled at clk rise.
REQ-005 op  input  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
REQ-006 a  input  32  operand A (multiplicand / dividend), sampled with start.
REQ-007 b  input  32  operand B (multiplier / divisor), sampled with start.
REQ-008 cancel  input  1  pipeline flush on interrupt/exception; aborts the operation in flight.
REQ-009 busy  output  1  operation in flight; new start ignored.
REQ-010 done  output  1  one-cycle pulse; hi/lo/err valid.
REQ-011 hi  output  32  product[63:32] / remainder.
REQ-012 lo  output  32  product[31:0] / quotient.
REQ-013 err  output  1  divide-by-zero or unsupported op; valid with done.

Function
REQ-014 FSM states: IDLE, PREP, RUN, FIX, DONE; one transition per clk rise.
REQ-015 start accepted only in IDLE or DONE (back-to-back allowed); operands and op latched on the accepting edge; start in PREP/RUN/FIX ignored.
REQ-016 PREP: signed ops take absolute values of a and b into internal registers and record result signs; unsigned ops copy unchanged.
REQ-017 RUN: exactly 32 iterations, one per cycle, 6-bit counter 0..31; multiply is shift-add (one 33-bit add, 1-bit right shift of the 64-bit accumulator); divide is restoring (1-bit left shift, 33-bit trial subtract, quotient bit = no borrow).
REQ-018 FIX: negate product if sign(a)^sign(b) (signed MULT); quotient negated if sign(a)^sign(b), remainder takes sign(a) (signed DIV); hi/lo updated on the FIX->DONE edge only.
REQ-019 Latency: accept on edge 0; done high between edges 35 and 36; busy high between edges 0 and 35; busy and done never high together.
REQ-020 Divide by zero (b=0, DIV/DIVU): PREP goes directly to DONE; hi=a, lo=32'hFFFFFFFF, err=1; done between edges 2 and 3.
REQ-021 Signed overflow 0x80000000 / 0xFFFFFFFF: lo=32'h80000000, hi=0, err=0.
REQ-022 cancel high at a clk rise in any state: next state IDLE, done not asserted, hi/lo/err keep previous values; cancel with start in the same cycle: cancel wins, start dropped.
REQ-023 err low for all MULT/MULTU results and for non-zero-divisor divides.
REQ-024 hi/lo hold their last value until the next completed operation.

Reset
REQ-025 clrn low: state IDLE, counter 0, busy=0, done=0, err=0, hi=0, lo=0, all internal operand/accumulator registers 0, independent of clk.
REQ-026 clrn asserted mid-operation discards it with no done; first start after release behaves as from cold reset.

Configuration
REQ-027 Macro MDU_DIV_EN: when defined, DIV/DIVU implemented per REQ-017..021.
REQ-028 MDU_DIV_EN undefined: no divide hardware; op 10/11 goes IDLE->DONE, done between edges 1 and 2, hi=lo=0, err=1; multiply unaffected.

Structure
REQ-029 Package mdu_pkg holds op encodings (MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU), FSM state encodings, iteration count constant 32.
REQ-030 One sub-module, mdu_step: combinational single-iteration datapath (33-bit add/sub plus shift, mode select mul/div) instantiated once; mdu_seq holds FSM, counter, registers.

Verification
REQ-031 MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done at edge 35, hi=0xFFFFFFFE, lo=0x00000001, err=0.
REQ-032 MULT a=-3 (0xFFFFFFFD) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; DIV a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-033 DIVU a=100 b=0 -> done at edge 2, hi=100, lo=0xFFFFFFFF, err=1 (without MDU_DIV_EN: done at edge 1, hi=lo=0, err=1).
REQ-034 MULTU 5*6 completes (lo=30); then MULT started, cancel at edge 10 -> busy low after edge 11, no done, hi/lo stay 0/30; restart completes normally.
REQ-035 Back-to-back: start held high during DONE -> second op accepted on that edge, second done 35 edges later; start pulses while busy ignored; clrn pulse mid-RUN -> all outputs 0 immediately.
